// File: rtl/result_bcd_scanner_pkg.sv
// ----------------------------------------------------------------------------
// result_bcd_scanner_pkg
//
// Purpose: shared types, constants and helpers for the result BCD scanner and
//          for any other binary-to-BCD logic built on the double-dabble step.
//
// Contents:
//   state_t      scanner FSM states (idle, converting a byte, showing a byte)
//   BYTE_W       width of one displayed byte
//   BCD_W        width of the 3-digit BCD result {hundreds, tens, units}
//   DD_W         width of the double-dabble working word {BCD, binary}
//   DD_STEPS     shift steps needed to convert one byte
//   WORD_W       width of a captured cipher/decipher result
//   IDX_W        width of the byte index
//   msb_byte()   byte selection helper; byte 0 is the most significant byte
//   dd_add3()    per-digit correction applied before each shift
// ----------------------------------------------------------------------------
package result_bcd_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StShow
    } state_t;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BCD_W    = 12;
    localparam int unsigned DD_W     = BCD_W + BYTE_W;
    localparam int unsigned DD_STEPS = 8;
    localparam int unsigned WORD_W   = 128;
    localparam int unsigned IDX_W    = 4;

    // Byte 0 sits in word[127:120]; shifting the wanted byte up to the top
    // avoids a variable part-select and keeps the index arithmetic 4 bits wide.
    function automatic logic [BYTE_W-1:0] msb_byte(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx);
        logic [WORD_W-1:0] w_shifted;
        w_shifted = word << {idx, 3'b000};
        return w_shifted[WORD_W-1 -: BYTE_W];
    endfunction

    // A digit of 5 or more would exceed 9 after doubling, so pre-add 3 so the
    // shift carries cleanly into the next digit.
    function automatic logic [3:0] dd_add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/result_bcd_scanner_dd_step.sv
// ----------------------------------------------------------------------------
// result_bcd_scanner_dd_step
//
// Purpose: one combinational double-dabble step on a 20-bit working word
//          {hundreds, tens, units, binary[7:0]}: every BCD digit that is 5 or
//          more gets +3, then the whole word shifts left by one bit.
//          Eight applications starting from {12'b0, byte} leave the 3-digit BCD
//          value of the byte in bits [19:8].
//
// Ports:
//   i_word   in   20  working word before the step
//   o_word   out  20  working word after add-3 and shift
// ----------------------------------------------------------------------------
module result_bcd_scanner_dd_step
    import result_bcd_scanner_pkg::*;
(
    input  logic [DD_W-1:0] i_word,
    output logic [DD_W-1:0] o_word
);

    logic [DD_W-1:0] w_adj;

    always_comb begin
        w_adj = i_word;
        for (int d = 0; d < 3; d++) begin
            w_adj[BYTE_W + 4*d +: 4] = dd_add3(i_word[BYTE_W + 4*d +: 4]);
        end
    end

    assign o_word = {w_adj[DD_W-2:0], 1'b0};

endmodule

// File: rtl/result_bcd_scanner.sv
// ----------------------------------------------------------------------------
// result_bcd_scanner
//
// Purpose: captures a 128-bit AES result and walks its 16 bytes MSB-first.
//          Each byte is converted to 3-digit BCD by a sequential double-dabble
//          (one step per cycle, 8 cycles per byte) and then held on bcd_out for
//          DWELL_CYCLES cycles so every byte of the block reaches the HEX
//          displays. A load at any time restarts the walk from byte 0.
//
// Parameters:
//   DWELL_CYCLES  cycles each byte is shown (minimum 1)
//   NBYTES        bytes walked per captured word
//   CW            dwell counter width, 2**CW >= DWELL_CYCLES
//
// Ports:
//   clk        in   1    system clock, rising edge
//   reset      in   1    synchronous active-low reset, priority over all
//   load       in   1    one-cycle capture strobe for data_in
//   data_in    in   128  result to display, byte 0 = data_in[127:120]
//   hold       in   1    freezes the dwell counter while high (SHOW only)
//   busy       out  1    high while converting or showing
//   byte_idx   out  4    index of the byte being converted/shown
//   bcd_out    out  12   {hundreds, tens, units} of the current byte
//   bcd_valid  out  1    high only while a byte is being shown
//   done       out  1    one-cycle pulse after the last byte's dwell
// ----------------------------------------------------------------------------
module result_bcd_scanner
    import result_bcd_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned NBYTES       = 16,
    parameter int unsigned CW           = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [WORD_W-1:0]   data_in,
    input  logic                hold,
    output logic                busy,
    output logic [IDX_W-1:0]    byte_idx,
    output logic [BCD_W-1:0]    bcd_out,
    output logic                bcd_valid,
    output logic                done
);

    localparam logic [CW-1:0]    DWELL_TC  = CW'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [2:0]       STEP_LAST = 3'(DD_STEPS - 1);

    state_t              r_state;
    logic [WORD_W-1:0]   r_capture;
    logic [DD_W-1:0]     r_work;
    logic [2:0]          r_step;
    logic [CW-1:0]       r_dwell;
    logic [IDX_W-1:0]    r_idx;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_valid;
    logic                r_done;
    logic                r_busy;

    logic [DD_W-1:0]     w_dd_next;

    result_bcd_scanner_dd_step u_dd_step (
        .i_word (r_work),
        .o_word (w_dd_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_capture <= '0;
            r_work    <= '0;
            r_step    <= '0;
            r_dwell   <= '0;
            r_idx     <= '0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                // Restart from byte 0 in every state; an aborted frame never
                // reaches its terminal count, so it never pulses done.
                r_capture <= data_in;
                r_idx     <= '0;
                r_work    <= {{BCD_W{1'b0}}, msb_byte(data_in, '0)};
                r_step    <= '0;
                r_valid   <= 1'b0;
                r_busy    <= 1'b1;
                r_state   <= StConvert;
            end else begin
                unique case (r_state)
                    StIdle: begin
                    end
                    StConvert: begin
                        if (r_step == STEP_LAST) begin
                            // Last step result goes straight to the output
                            r_bcd   <= w_dd_next[DD_W-1 -: BCD_W];
                            r_valid <= 1'b1;
                            r_dwell <= '0;
                            r_state <= StShow;
                        end else begin
                            r_work <= w_dd_next;
                            r_step <= r_step + 3'd1;
                        end
                    end
                    StShow: begin
                        if (!hold) begin
                            if (r_dwell == DWELL_TC) begin
                                r_valid <= 1'b0;
                                if (r_idx < LAST_IDX) begin
                                    r_idx   <= r_idx + 1'b1;
                                    r_work  <= {{BCD_W{1'b0}},
                                                msb_byte(r_capture, r_idx + 1'b1)};
                                    r_step  <= '0;
                                    r_state <= StConvert;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= StIdle;
                                end
                            end else begin
                                r_dwell <= r_dwell + CW'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign byte_idx  = r_idx;
    assign bcd_out   = r_bcd;
    assign bcd_valid = r_valid;
    assign done      = r_done;

endmodule

// File: doc/result_bcd_scanner.md
Name: result_bcd_scanner

Overview:
Display-side stage that sits directly downstream of the AES cipher/decipher cores and directly upstream of the BCD-to-7-segment decoder.
- Captures a 128-bit cipher or decipher result on a load strobe.
- Walks its 16 bytes MSB-first, converting each byte to 3-digit BCD with a sequential double-dabble, one shift step per cycle.
- Presents each converted byte for a programmable dwell time, so the whole block is visible on the board's HEX displays, not only byte 0.

Parameters:
- DWELL_CYCLES, 50_000_000: cycles each byte is shown in SHOW. Minimum 1.
- NBYTES, 16: bytes per captured word. Byte 0 = data_in[127:120].
- CW, 26: dwell counter width. Must satisfy 2^CW >= DWELL_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- load  in  1  one-cycle capture strobe for data_in.
- data_in  in  128  cipher/decipher result to display.
- hold  in  1  freezes the dwell counter while high.
- busy  out  1  high in CONVERT and SHOW.
- byte_idx  out  4  index of the byte currently converted/shown.
- bcd_out  out  12  {hundreds, tens, units} of the current byte.
- bcd_valid  out  1  high only in SHOW; bcd_out is stable.
- done  out  1  one-cycle pulse after the last byte's dwell expires.

Behaviour:
- Reset (reset==0 at an edge):
  - State IDLE.
  - busy=0, byte_idx=0, bcd_out=12'h000, bcd_valid=0, done=0.
  - Capture register and dwell counter cleared.
  - Reset has priority over load and hold.
- States: IDLE, CONVERT, SHOW.
- IDLE, load=1 at edge N:
  - Capture data_in; byte_idx<=0.
  - Load working register {12'b0, byte}; step counter<=0; go to CONVERT.
- CONVERT:
  - Each edge applies one double-dabble step: any BCD nibble >=5 gets +3, then the 20-bit word shifts left by 1.
  - The 8th step lands at edge N+8. At that edge: bcd_out<=result, bcd_valid<=1, dwell<=0, go to SHOW.
  - Latency from load edge to valid bcd_out: 8 cycles.
  - hold is ignored in CONVERT.
- SHOW:
  - Dwell counter increments each edge with hold=0 and freezes with hold=1.
  - Terminal count DWELL_CYCLES-1 with hold=0:
    - If byte_idx < NBYTES-1: byte_idx+1, bcd_valid<=0, load next byte, go to CONVERT.
    - Else: done<=1 for one cycle, bcd_valid<=0, go to IDLE.
  - bcd_out keeps the previous value during CONVERT and after done.
- Per-byte period: 8+DWELL_CYCLES cycles. Frame length: NBYTES*(8+DWELL_CYCLES) cycles.
- load while busy:
  - Abort the current frame, recapture data_in, byte_idx<=0, go to CONVERT, bcd_valid<=0.
  - No done pulse for the aborted frame.
- load coincident with the last terminal count: load wins, and done is not asserted.
- byte_idx never wraps on its own; the frame ends at NBYTES-1.
- Arithmetic:
  - Every BCD digit is always in 0..9.
  - bcd_out[11:8] is always in 0..2.

Decomposition:
- Shared package:
  - State enum (IDLE/CONVERT/SHOW).
  - BCD_W=12 and DD_STEPS=8 constants.
  - The byte-order convention (byte 0 = MSB).
- One combinational sub-module, dd_step: 20-bit in -> 20-bit out, add-3-then-shift.
  - Reusable by the existing binary-to-BCD converter.

Test Plan (bench uses DWELL_CYCLES=4, giving a 12-cycle byte period and a 192-cycle frame):
1. Reset: hold reset=0 for 2 cycles with load=1 -> busy=0, bcd_out=000, byte_idx=0, bcd_valid=0, done=0, and load is ignored.
2. Load 69c4e0d86a7b0430d8cdb78070b4c55a:
   - 8 cycles later: bcd_valid=1, idx 0, bcd_out 0x105, held for 4 cycles.
   - Next byte, idx 1: 0x196.
   - Idx 15: 0x090.
   - done pulses one cycle at frame cycle 192, then busy=0.
3. Load 00ff99...00 (bytes 0x00, 0xFF, 0x99) -> bcd_out 0x000, 0x255, 0x153 on idx 0, 1, 2.
4. hold=1 for 10 cycles during SHOW of idx 3 -> dwell extends to 14 cycles, idx stays 3, bcd_out stable; hold asserted during CONVERT has no effect.
5. Load new data (byte 0 = 0x0A) during SHOW of idx 5 -> idx returns to 0, bcd_out 0x010 after 8 cycles, no done pulse for the aborted frame.
6. reset=0 mid-CONVERT of idx 7 -> next edge all outputs at reset values; after release, IDLE until the next load.
